// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: inter-stage pipeline register for the 8-bit RISC pipeline.
// Carries NUM_OPS operand lanes plus ra/rb/ctrl/flags sideband fields.
// Flow control is valid/ready with a 2-entry skid buffer. The skid buffer keeps
// full throughput, and in_ready depends only on registered state (and rst).
// A synchronous flush squashes every held entry.
// Optional feature: define PIPE_STAGE_PERF_EN to add the saturating stall and
// flush performance counters (perf_stall_cnt, perf_flush_cnt).
module pipe_stage_skid_reg #(
  parameter int DATA_W  = 8,
  parameter int NUM_OPS = 6,
  parameter int RIDX_W  = 2,
  parameter int CTRL_W  = 4,
  parameter int FLAG_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_OPS*DATA_W-1:0] in_ops,
  input  logic [RIDX_W-1:0]         in_ra,
  input  logic [RIDX_W-1:0]         in_rb,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [FLAG_W-1:0]         in_flags,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_OPS*DATA_W-1:0] out_ops,
  output logic [RIDX_W-1:0]         out_ra,
  output logic [RIDX_W-1:0]         out_rb,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [FLAG_W-1:0]         out_flags
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]               perf_stall_cnt,
  output logic [15:0]               perf_flush_cnt
`endif
);

  typedef struct packed {
    logic [NUM_OPS*DATA_W-1:0] ops;
    logic [RIDX_W-1:0]         ra;
    logic [RIDX_W-1:0]         rb;
    logic [CTRL_W-1:0]         ctrl;
    logic [FLAG_W-1:0]         flags;
  } entry_t;

  // The encoding makes bit 0 the main-register valid and bit 1 the skid-register valid.
  // Both valid bits therefore come straight out of flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } occ_e;

  occ_e   state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;
  logic   main_valid;
  logic   skid_valid;
  logic   push;
  logic   pop;

  assign in_entry   = '{ops: in_ops, ra: in_ra, rb: in_rb, ctrl: in_ctrl, flags: in_flags};
  assign main_valid = state[0];
  assign skid_valid = state[1];

  // in_ready depends only on the skid flop and rst. It has no combinational path from out_ready.
  assign in_ready  = ~skid_valid & ~rst;
  assign push      = in_valid & in_ready;
  assign pop       = main_valid & out_ready;

  assign out_valid = main_valid;
  assign out_ops   = main_q.ops;
  assign out_ra    = main_q.ra;
  assign out_rb    = main_q.rb;
  assign out_ctrl  = main_q.ctrl;
  assign out_flags = main_q.flags;

  // Occupancy FSM and data movement. Data registers load only on push or on a skid->main move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: every register here is a flop, so the data registers can be reset.
      // They are cleared so that out_* read zero while the stage is in reset.
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      // Clearing the valid bits is enough. Stale data is never presented as valid.
      state <= EMPTY;
    end else begin
      // NOTE: non-blocking assignments let main_q read the old skid_q in the same edge.
      case (state)
        EMPTY: begin
          if (push) begin
            main_q <= in_entry;
            state  <= ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_q <= in_entry;
          end else if (push) begin
            skid_q <= in_entry;
            state  <= FULL;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Saturating performance counters. Reset clears them; flush does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && perf_stall_cnt != 16'hFFFF)
        perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (flush && (main_valid || skid_valid) && perf_flush_cnt != 16'hFFFF)
        perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule
